// File: rtl/mem_1rw_arb.sv
// Round-robin arbiter/sequencer sharing one single-port memory between two requesters.
// Registers all memory controls, tracks the 1-cycle read latency and drops out-of-range accesses.
module mem_1rw_arb #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned WORD_BYTES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    rq0_req,
    input  logic                    rq0_we,
    input  logic [ADDR_WIDTH-1:0]   rq0_addr,
    input  logic [8*WORD_BYTES-1:0] rq0_wr_data,
    input  logic [WORD_BYTES-1:0]   rq0_be,
    output logic                    rq0_gnt,
    output logic                    rq0_rd_vld,
    output logic [8*WORD_BYTES-1:0] rq0_rd_data,
    output logic                    rq0_err,

    input  logic                    rq1_req,
    input  logic                    rq1_we,
    input  logic [ADDR_WIDTH-1:0]   rq1_addr,
    input  logic [8*WORD_BYTES-1:0] rq1_wr_data,
    input  logic [WORD_BYTES-1:0]   rq1_be,
    output logic                    rq1_gnt,
    output logic                    rq1_rd_vld,
    output logic [8*WORD_BYTES-1:0] rq1_rd_data,
    output logic                    rq1_err,

    output logic                    mem_ce,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wr_data,
    output logic [WORD_BYTES-1:0]   mem_be,
    input  logic [8*WORD_BYTES-1:0] mem_rd_data
);

    localparam int unsigned DATA_WIDTH = 8 * WORD_BYTES;

    // last_gnt: 0 = rq0 was granted last, 1 = rq1 was granted last
    logic                  last_gnt;
    logic                  gnt0_c;
    logic                  gnt1_c;
    logic                  any_gnt_c;
    logic                  sel_we_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;
    logic [DATA_WIDTH-1:0] sel_wr_data_c;
    logic [WORD_BYTES-1:0] sel_be_c;
    logic                  in_range_c;

    // Stage-1 bookkeeping for the access currently presented to the memory
    logic                  s1_rd;
    logic                  s1_err;
    logic                  s1_owner;

    // Arbitration and request mux; grants are held off while reset is asserted
    always_comb begin
        gnt0_c        = rst_n & rq0_req & (~rq1_req | last_gnt);
        gnt1_c        = rst_n & rq1_req & (~rq0_req | ~last_gnt);
        any_gnt_c     = gnt0_c | gnt1_c;
        sel_we_c      = rq0_we;
        sel_addr_c    = rq0_addr;
        sel_wr_data_c = rq0_wr_data;
        sel_be_c      = rq0_be;
        if (gnt1_c) begin
            sel_we_c      = rq1_we;
            sel_addr_c    = rq1_addr;
            sel_wr_data_c = rq1_wr_data;
            sel_be_c      = rq1_be;
        end
        in_range_c = 32'(sel_addr_c) < MEM_DEPTH;
    end

    assign rq0_gnt = gnt0_c;
    assign rq1_gnt = gnt1_c;

    // Issue stage: memory controls and pending-access tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt    <= 1'b1;
            mem_ce      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_be      <= '0;
            s1_rd       <= 1'b0;
            s1_err      <= 1'b0;
            s1_owner    <= 1'b0;
        end else if (any_gnt_c) begin
            last_gnt <= gnt1_c;
            s1_owner <= gnt1_c;
            if (in_range_c) begin
                mem_ce      <= 1'b1;
                mem_we      <= sel_we_c;
                mem_addr    <= sel_addr_c;
                mem_wr_data <= sel_wr_data_c;
                mem_be      <= sel_be_c;
                s1_rd       <= ~sel_we_c;
                s1_err      <= 1'b0;
            end else begin
                mem_ce <= 1'b0;
                mem_we <= 1'b0;
                s1_rd  <= 1'b0;
                s1_err <= 1'b1;
            end
        end else begin
            mem_ce <= 1'b0;
            mem_we <= 1'b0;
            s1_rd  <= 1'b0;
            s1_err <= 1'b0;
        end
    end

    // Completion stage: route the response pulse to the owner of the access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq0_rd_vld <= 1'b0;
            rq1_rd_vld <= 1'b0;
            rq0_err    <= 1'b0;
            rq1_err    <= 1'b0;
        end else begin
            rq0_rd_vld <= s1_rd  & ~s1_owner;
            rq1_rd_vld <= s1_rd  &  s1_owner;
            rq0_err    <= s1_err & ~s1_owner;
            rq1_err    <= s1_err &  s1_owner;
        end
    end

    // Memory read data arrives in the completion cycle; mask it for the non-owner
    assign rq0_rd_data = rq0_rd_vld ? mem_rd_data : '0;
    assign rq1_rd_data = rq1_rd_vld ? mem_rd_data : '0;

endmodule

// File: tb/tb_mem_1rw_arb.sv
// Directed self-checking bench for mem_1rw_arb, with a behavioural 1-cycle-latency memory.
module tb_mem_1rw_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rq0_req, rq0_we, rq1_req, rq1_we;
    logic [7:0]  rq0_addr, rq1_addr, rq0_be, rq1_be;
    logic [63:0] rq0_wr_data, rq1_wr_data;
    logic        rq0_gnt, rq0_rd_vld, rq0_err, rq1_gnt, rq1_rd_vld, rq1_err;
    logic [63:0] rq0_rd_data, rq1_rd_data;
    logic        mem_ce, mem_we;
    logic [7:0]  mem_addr, mem_be;
    logic [63:0] mem_wr_data, mem_rd_data;

    logic        mem_load;
    logic        oob_hit;
    logic [63:0] mem [256];
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_1rw_arb #(.ADDR_WIDTH(8), .MEM_DEPTH(200), .WORD_BYTES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wr_data(rq0_wr_data),
        .rq0_be(rq0_be), .rq0_gnt(rq0_gnt), .rq0_rd_vld(rq0_rd_vld), .rq0_rd_data(rq0_rd_data),
        .rq0_err(rq0_err),
        .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wr_data(rq1_wr_data),
        .rq1_be(rq1_be), .rq1_gnt(rq1_gnt), .rq1_rd_vld(rq1_rd_vld), .rq1_rd_data(rq1_rd_data),
        .rq1_err(rq1_err),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_be(mem_be), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Memory model: word i preloaded with byte value i repeated; garbage when not reading
    always @(posedge clk) begin
        mem_rd_data <= 64'hDEAD_BEEF_DEAD_BEEF;
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] = 64'(i) * 64'h0101_0101_0101_0101;
            mem[3] = 64'h0123_4567_89AB_CDEF;
            mem[5] = 64'h1122_3344_5566_7788;
            oob_hit <= 1'b0;
        end else if (mem_ce) begin
            if (mem_addr >= 8'd200) oob_hit <= 1'b1;
            if (mem_we) begin
                for (int b = 0; b < 8; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] = mem_wr_data[8*b +: 8];
            end else begin
                mem_rd_data <= mem[mem_addr];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rq0_req = 1'b1; rq1_req = 1'b1;
        #1;
        n_checks++;
        if ({rq0_gnt, rq1_gnt} !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnt: got %b want 00", {rq0_gnt, rq1_gnt});
        end
        n_checks++;
        if ({mem_ce, mem_we, mem_addr, mem_wr_data, mem_be} !== 82'd0) begin
            n_fail++; $display("FAIL reset_mem: ce=%b we=%b addr=%h be=%h want 0", mem_ce, mem_we, mem_addr, mem_be);
        end
        step();
        n_checks++;
        if ({rq0_rd_vld, rq1_rd_vld, rq0_err, rq1_err, rq0_rd_data, rq1_rd_data} !== 132'd0) begin
            n_fail++; $display("FAIL reset_resp: vld=%b%b err=%b%b d0=%h d1=%h want 0",
                               rq0_rd_vld, rq1_rd_vld, rq0_err, rq1_err, rq0_rd_data, rq1_rd_data);
        end
        step();
        mem_load = 1'b0; rq0_req = 1'b0; rq1_req = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        rq0_req = 1'b1; rq0_we = 1'b0; rq0_addr = 8'd5; rq0_be = 8'hFF;
        #1;
        n_checks++;
        if ({rq0_gnt, rq1_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL single_gnt: got %b want 10", {rq0_gnt, rq1_gnt});
        end
        step();
        rq0_req = 1'b0;
        n_checks++;
        if ({mem_ce, mem_we, mem_addr} !== {1'b1, 1'b0, 8'd5}) begin
            n_fail++; $display("FAIL single_issue: ce=%b we=%b addr=%0d want 1 0 5", mem_ce, mem_we, mem_addr);
        end
        step();
        n_checks++;
        if (rq0_rd_vld !== 1'b1 || rq0_rd_data !== 64'h1122_3344_5566_7788) begin
            n_fail++; $display("FAIL single_data: vld=%b data=%h want 1 1122334455667788", rq0_rd_vld, rq0_rd_data);
        end
        n_checks++;
        if (rq1_rd_vld !== 1'b0 || rq1_rd_data !== 64'd0) begin
            n_fail++; $display("FAIL single_other: vld=%b data=%h want 0 0", rq1_rd_vld, rq1_rd_data);
        end
        step();
        n_checks++;
        if (rq0_rd_vld !== 1'b0) begin
            n_fail++; $display("FAIL single_pulse: vld=%b want 0", rq0_rd_vld);
        end
        step();
    endtask

    task automatic test_contention();
        logic [5:0] exp_g1;
        exp_g1 = 6'b010101;   // rq0 was granted last, so rq1 wins first
        rq0_req = 1'b1; rq0_we = 1'b0; rq0_addr = 8'd10;
        rq1_req = 1'b1; rq1_we = 1'b0; rq1_addr = 8'd11; rq1_be = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) begin rq0_req = 1'b0; rq1_req = 1'b0; end
            #1;
            if (i < 6) begin
                n_checks++;
                if ({rq0_gnt, rq1_gnt} !== {~exp_g1[i], exp_g1[i]}) begin
                    n_fail++; $display("FAIL contention_gnt[%0d]: got %b want %b", i, {rq0_gnt, rq1_gnt}, {~exp_g1[i], exp_g1[i]});
                end
            end
            if (i >= 1 && i <= 6) begin
                n_checks++;
                if (mem_ce !== 1'b1 || mem_addr !== (exp_g1[i-1] ? 8'd11 : 8'd10)) begin
                    n_fail++; $display("FAIL contention_issue[%0d]: ce=%b addr=%0d", i, mem_ce, mem_addr);
                end
            end
            if (i >= 2) begin
                n_checks++;
                if (exp_g1[i-2] ? (rq1_rd_vld !== 1'b1 || rq1_rd_data !== 64'h0B0B_0B0B_0B0B_0B0B ||
                                   rq0_rd_vld !== 1'b0 || rq0_rd_data !== 64'd0)
                                : (rq0_rd_vld !== 1'b1 || rq0_rd_data !== 64'h0A0A_0A0A_0A0A_0A0A ||
                                   rq1_rd_vld !== 1'b0 || rq1_rd_data !== 64'd0)) begin
                    n_fail++; $display("FAIL contention_resp[%0d]: vld=%b%b d0=%h d1=%h", i,
                                       rq0_rd_vld, rq1_rd_vld, rq0_rd_data, rq1_rd_data);
                end
            end
            step();
        end
    endtask

    task automatic test_write_read();
        rq1_req = 1'b1; rq1_we = 1'b1; rq1_addr = 8'd3; rq1_be = 8'h0F;
        rq1_wr_data = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        n_checks++;
        if ({rq0_gnt, rq1_gnt} !== 2'b01) begin
            n_fail++; $display("FAIL wr_gnt: got %b want 01", {rq0_gnt, rq1_gnt});
        end
        step();
        rq1_we = 1'b0;
        #1;
        n_checks++;
        if (rq1_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rd_gnt: got %b want 1", rq1_gnt);
        end
        n_checks++;
        if ({mem_ce, mem_we, mem_be, mem_addr} !== {1'b1, 1'b1, 8'h0F, 8'd3}) begin
            n_fail++; $display("FAIL wr_issue: ce=%b we=%b be=%h addr=%0d want 1 1 0f 3", mem_ce, mem_we, mem_be, mem_addr);
        end
        step();
        rq1_req = 1'b0;
        n_checks++;
        if ({mem_ce, mem_we, rq1_rd_vld, rq1_err} !== 4'b1000) begin
            n_fail++; $display("FAIL wr_noresp: ce=%b we=%b vld=%b err=%b want 1 0 0 0", mem_ce, mem_we, rq1_rd_vld, rq1_err);
        end
        step();
        n_checks++;
        if (rq1_rd_vld !== 1'b1 || rq1_rd_data !== 64'h0123_4567_CCCC_DDDD) begin
            n_fail++; $display("FAIL wr_rd_data: vld=%b data=%h want 1 01234567ccccdddd", rq1_rd_vld, rq1_rd_data);
        end
        step();
    endtask

    task automatic test_out_of_range();
        rq0_req = 1'b1; rq0_we = 1'b0; rq0_addr = 8'd210;
        #1;
        n_checks++;
        if ({rq0_gnt, rq1_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL oob_gnt0: got %b want 10", {rq0_gnt, rq1_gnt});
        end
        step();
        rq0_req = 1'b0;
        rq1_req = 1'b1; rq1_we = 1'b1; rq1_addr = 8'd200; rq1_be = 8'hFF; rq1_wr_data = 64'h5555;
        #1;
        n_checks++;
        if (rq1_gnt !== 1'b1 || mem_ce !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL oob_issue210: gnt1=%b ce=%b we=%b want 1 0 0", rq1_gnt, mem_ce, mem_we);
        end
        step();
        rq1_req = 1'b0;
        rq0_req = 1'b1; rq0_we = 1'b0; rq0_addr = 8'd199;
        #1;
        n_checks++;
        if (rq0_gnt !== 1'b1 || mem_ce !== 1'b0) begin
            n_fail++; $display("FAIL oob_issue200: gnt0=%b ce=%b want 1 0", rq0_gnt, mem_ce);
        end
        n_checks++;
        if ({rq0_err, rq0_rd_vld, rq1_err} !== 3'b100 || rq0_rd_data !== 64'd0) begin
            n_fail++; $display("FAIL oob_err0: err0=%b vld0=%b err1=%b d0=%h want 1 0 0 0", rq0_err, rq0_rd_vld, rq1_err, rq0_rd_data);
        end
        step();
        rq0_req = 1'b0;
        n_checks++;
        if ({rq1_err, rq0_err, rq1_rd_vld} !== 3'b100) begin
            n_fail++; $display("FAIL oob_err1: err1=%b err0=%b vld1=%b want 1 0 0", rq1_err, rq0_err, rq1_rd_vld);
        end
        n_checks++;
        if (mem_ce !== 1'b1 || mem_addr !== 8'd199) begin
            n_fail++; $display("FAIL oob_edge_issue: ce=%b addr=%0d want 1 199", mem_ce, mem_addr);
        end
        step();
        n_checks++;
        if (rq0_rd_vld !== 1'b1 || rq0_rd_data !== 64'hC7C7_C7C7_C7C7_C7C7 || {rq0_err, rq1_err} !== 2'b00) begin
            n_fail++; $display("FAIL oob_edge_data: vld=%b data=%h err=%b%b want 1 c7c7c7c7c7c7c7c7 00",
                               rq0_rd_vld, rq0_rd_data, rq0_err, rq1_err);
        end
        step();
        n_checks++;
        if (oob_hit !== 1'b0) begin
            n_fail++; $display("FAIL oob_mem_access: memory saw addr >= 200 (flag=%b) want 0", oob_hit);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({mem_ce, mem_we, rq0_gnt, rq1_gnt, rq0_rd_vld, rq1_rd_vld, rq0_err, rq1_err} !== 8'd0 ||
                rq0_rd_data !== 64'd0 || rq1_rd_data !== 64'd0) begin
                n_fail++; $display("FAIL idle[%0d]: ce=%b we=%b gnt=%b%b vld=%b%b err=%b%b want all 0", i,
                                   mem_ce, mem_we, rq0_gnt, rq1_gnt, rq0_rd_vld, rq1_rd_vld, rq0_err, rq1_err);
            end
            step();
        end
        rq0_req = 1'b1; rq0_addr = 8'd10; rq1_req = 1'b1; rq1_we = 1'b0; rq1_addr = 8'd11;
        #1;
        n_checks++;
        if ({rq0_gnt, rq1_gnt} !== 2'b01) begin
            n_fail++; $display("FAIL idle_last_gnt: got %b want 01", {rq0_gnt, rq1_gnt});
        end
        step();
        rq0_req = 1'b0; rq1_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid_burst();
        rq0_req = 1'b1; rq1_req = 1'b1;
        step();
        step();
        step();
        n_checks++;
        if (mem_ce !== 1'b1) begin
            n_fail++; $display("FAIL burst_active: ce=%b want 1", mem_ce);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_ce, mem_we, mem_addr, mem_wr_data, mem_be, rq0_gnt, rq1_gnt,
             rq0_rd_vld, rq1_rd_vld, rq0_err, rq1_err} !== 88'd0 ||
            rq0_rd_data !== 64'd0 || rq1_rd_data !== 64'd0) begin
            n_fail++; $display("FAIL midreset_outputs: ce=%b we=%b addr=%h be=%h gnt=%b%b vld=%b%b err=%b%b want all 0",
                               mem_ce, mem_we, mem_addr, mem_be, rq0_gnt, rq1_gnt,
                               rq0_rd_vld, rq1_rd_vld, rq0_err, rq1_err);
        end
        rq0_req = 1'b0; rq1_req = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if ({rq0_rd_vld, rq1_rd_vld, rq0_err, rq1_err, mem_ce} !== 5'd0) begin
                n_fail++; $display("FAIL midreset_stale[%0d]: vld=%b%b err=%b%b ce=%b want 0", i,
                                   rq0_rd_vld, rq1_rd_vld, rq0_err, rq1_err, mem_ce);
            end
        end
        rq0_req = 1'b1; rq1_req = 1'b1;
        #1;
        n_checks++;
        if ({rq0_gnt, rq1_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL midreset_first_gnt: got %b want 10", {rq0_gnt, rq1_gnt});
        end
        step();
        rq0_req = 1'b0; rq1_req = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst_n = 1'b0; mem_load = 1'b1;
        rq0_req = 1'b0; rq0_we = 1'b0; rq0_addr = '0; rq0_wr_data = '0; rq0_be = '0;
        rq1_req = 1'b0; rq1_we = 1'b0; rq1_addr = '0; rq1_wr_data = '0; rq1_be = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_write_read();
        test_out_of_range();
        test_idle();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
